// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, parity modes and parity helper for the UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Even parity makes the total count of ones even; odd inverts that.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period counter; pulses bit_done on the last cycle of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // restart wins over the natural wrap so every state begins a full period
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
        end else if (bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign bit_done = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : UART transmitter draining a registered-read byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_rdata,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam logic [2:0] c_LAST_STOP = 3'(STOP_BITS - 1);

    uart_tx_state_t r_state, w_state_next;
    logic [7:0]     r_shreg, w_shreg_next;
    logic [2:0]     r_bit_idx, w_bit_idx_next;
    logic           r_par, w_par_next;
    logic           r_tx, w_tx_next;
    logic [15:0]    r_frames;
    logic           w_rd_req;
    logic           w_frame_done;
    logic           w_bit_done;
    logic           w_restart;

    assign w_restart = (w_state_next != r_state);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .restart  (w_restart),
        .bit_done (w_bit_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_frames  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_shreg   <= w_shreg_next;
            r_bit_idx <= w_bit_idx_next;
            r_par     <= w_par_next;
            r_tx      <= w_tx_next;
            if (w_frame_done) begin
                r_frames <= r_frames + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shreg_next   = r_shreg;
        w_bit_idx_next = r_bit_idx;
        w_par_next     = r_par;
        w_rd_req       = 1'b0;
        w_frame_done   = 1'b0;
        w_tx_next      = 1'b1;

        unique case (r_state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    w_rd_req     = 1'b1;
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_shreg_next   = fifo_rdata;
                w_par_next     = parity_bit(fifo_rdata, PARITY);
                w_bit_idx_next = '0;
                w_state_next   = ST_START;
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_shreg_next = {1'b0, r_shreg[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_next = '0;
                        w_state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // bit index is reused to count stop bits
                if (w_bit_done) begin
                    if (r_bit_idx == c_LAST_STOP) begin
                        w_bit_idx_next = '0;
                        w_frame_done   = 1'b1;
                        w_state_next   = ST_IDLE;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Line level is registered from the next state so tx never glitches
        unique case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shreg_next[0];
            ST_PARITY: w_tx_next = w_par_next;
            default:   w_tx_next = 1'b1;
        endcase
    end

    assign fifo_rd_en  = w_rd_req & ~rst;
    assign busy        = (r_state != ST_IDLE) | fifo_rd_en;
    assign tx          = r_tx;
    assign frames_sent = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench for fifo_uart_tx with a byte FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fifo_clr = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int underreads = 0;
    int rd_times[$];
    logic [7:0] exp_q[$];

    // Main DUT and its 8-deep registered-read FIFO
    logic        wr_en = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        fifo_empty, fifo_full, fifo_rd_en, tx, busy;
    logic [7:0]  fifo_rdata;
    logic [15:0] frames_sent;
    logic [7:0]  fmem [8];
    logic [2:0]  fwp, frp;
    logic [3:0]  fcnt;

    assign fifo_empty = (fcnt == 4'd0);
    assign fifo_full  = (fcnt == 4'd8);

    always @(posedge clk) begin : fifo_model
        logic w, r;
        w = wr_en && !fifo_full;
        r = fifo_rd_en && !fifo_empty;
        if (fifo_clr) begin
            fwp <= 3'd0; frp <= 3'd0; fcnt <= 4'd0; fifo_rdata <= 8'h00;
        end else begin
            if (w) begin fmem[fwp] <= wdata; fwp <= fwp + 3'd1; end
            if (r) begin fifo_rdata <= fmem[frp]; frp <= frp + 3'd1; end
            fcnt <= fcnt + 4'(w) - 4'(r);
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .frames_sent(frames_sent)
    );

    // Parity / two-stop-bit DUTs fed by one-byte holding registers
    logic [7:0]  aux_wdata = 8'h00;
    logic        ev_wr = 1'b0, od_wr = 1'b0;
    logic        ev_empty, od_empty, ev_rd_en, od_rd_en, ev_tx, od_tx, ev_busy, od_busy;
    logic [7:0]  ev_hold, od_hold, ev_rdata, od_rdata;
    logic [15:0] ev_frames, od_frames;

    always @(posedge clk) begin
        if (rst) begin
            ev_empty <= 1'b1; od_empty <= 1'b1;
            ev_hold <= 8'h00; od_hold <= 8'h00; ev_rdata <= 8'h00; od_rdata <= 8'h00;
        end else begin
            if (ev_wr) begin ev_hold <= aux_wdata; ev_empty <= 1'b0; end
            else if (ev_rd_en) ev_empty <= 1'b1;
            if (ev_rd_en) ev_rdata <= ev_hold;
            if (od_wr) begin od_hold <= aux_wdata; od_empty <= 1'b0; end
            else if (od_rd_en) od_empty <= 1'b1;
            if (od_rd_en) od_rdata <= od_hold;
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut_ev (
        .clk(clk), .rst(rst), .fifo_empty(ev_empty), .fifo_rdata(ev_rdata),
        .fifo_rd_en(ev_rd_en), .tx(ev_tx), .busy(ev_busy), .frames_sent(ev_frames)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) dut_od (
        .clk(clk), .rst(rst), .fifo_empty(od_empty), .fifo_rdata(od_rdata),
        .fifo_rd_en(od_rd_en), .tx(od_tx), .busy(od_busy), .frames_sent(od_frames)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_rd_en) rd_times.push_back(cyc);
        if (fifo_rd_en && fifo_empty) underreads <= underreads + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic sel_tx(input int sel);
        case (sel)
            1: return ev_tx;
            2: return od_tx;
            default: return tx;
        endcase
    endfunction

    function automatic logic sel_busy(input int sel);
        case (sel)
            1: return ev_busy;
            2: return od_busy;
            default: return busy;
        endcase
    endfunction

    // Expected line bits, index 0 = start bit; unused upper bits stay 1
    function automatic logic [11:0] exp_frame(input logic [7:0] d, input int par);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (par == 1) f[9] = ^d;
        if (par == 2) f[9] = ~(^d);
        return f;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; fifo_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; fifo_clr = 1'b0;
    endtask

    task automatic fifo_write(input logic [7:0] d);
        wr_en = 1'b1; wdata = d;
        exp_q.push_back(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic aux_write(input int sel, input logic [7:0] d);
        aux_wdata = d;
        if (sel == 1) ev_wr = 1'b1; else od_wr = 1'b1;
        exp_q.push_back(d);
        @(posedge clk); #1;
        ev_wr = 1'b0; od_wr = 1'b0;
    endtask

    // Captures one frame; returns bit values and whether each bit was held
    // for all 4 cycles with busy high. Ends on the last cycle of the frame.
    task automatic rx_frame(input int sel, input int nbits, output logic [11:0] bits,
                            output bit stable, output int start_cyc, output bit timeout);
        int guard;
        guard = 0; timeout = 1'b0; stable = 1'b1; bits = '1; start_cyc = -1;
        @(negedge clk);
        while (sel_tx(sel) !== 1'b0) begin
            guard++;
            if (guard > 2000) begin timeout = 1'b1; return; end
            @(negedge clk);
        end
        start_cyc = cyc;
        for (int b = 0; b < nbits; b++) begin
            bits[b] = sel_tx(sel);
            if (sel_busy(sel) !== 1'b1) stable = 1'b0;
            for (int k = 1; k < 4; k++) begin
                @(negedge clk);
                if (sel_tx(sel) !== bits[b] || sel_busy(sel) !== 1'b1) stable = 1'b0;
            end
            if (b != nbits - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            total++;
            if ({tx, fifo_rd_en, busy, frames_sent} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got tx=%b rd=%b busy=%b frames=%0d want 1 0 0 0",
                         i, tx, fifo_rd_en, busy, frames_sent);
            end
        end
    endtask

    task automatic test_single();
        logic [11:0] bits, ef;
        logic [7:0] e;
        bit stable, to;
        int st, n0;
        do_reset();
        n0 = rd_times.size();
        fifo_write(8'hA5);
        rx_frame(0, 10, bits, stable, st, to);
        e = exp_q.pop_front();
        ef = exp_frame(e, 0);
        total++;
        if (to || bits[9:0] !== ef[9:0]) begin
            bad++;
            $display("FAIL single_frame got=%b want=%b timeout=%0b", bits[9:0], ef[9:0], to);
        end
        total++;
        if (!stable) begin bad++; $display("FAIL single_bit_hold got=0 want=1"); end
        total++;
        if (rd_times.size() != n0 + 1) begin
            bad++; $display("FAIL single_rd_count got=%0d want=1", rd_times.size() - n0);
        end
        total++;
        if (rd_times.size() == 0 || st - rd_times[rd_times.size()-1] != 2) begin
            bad++; $display("FAIL single_latency got start=%0d want rd+2", st);
        end
        @(negedge clk);
        total++;
        if ({busy, tx, frames_sent} !== {1'b0, 1'b1, 16'd1}) begin
            bad++;
            $display("FAIL single_end got busy=%b tx=%b frames=%0d want 0 1 1", busy, tx, frames_sent);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] bits, ef;
        logic [7:0] e;
        bit stable, to;
        int st, n;
        do_reset();
        fifo_write(8'h5A);
        fifo_write(8'hFF);
        for (int f = 0; f < 2; f++) begin
            rx_frame(0, 10, bits, stable, st, to);
            e = exp_q.pop_front();
            ef = exp_frame(e, 0);
            total++;
            if (to || !stable || bits[9:0] !== ef[9:0]) begin
                bad++;
                $display("FAIL b2b_frame%0d got=%b want=%b stable=%0b timeout=%0b",
                         f, bits[9:0], ef[9:0], stable, to);
            end
        end
        n = rd_times.size();
        total++;
        if (n < 2 || rd_times[n-1] - rd_times[n-2] != 42) begin
            bad++; $display("FAIL b2b_rd_spacing got=%0d want=42", (n < 2) ? -1 : rd_times[n-1] - rd_times[n-2]);
        end
        total++;
        if (fifo_empty !== 1'b1) begin bad++; $display("FAIL b2b_fifo_empty got=%b want=1", fifo_empty); end
        @(negedge clk);
        total++;
        if (frames_sent !== 16'd2) begin bad++; $display("FAIL b2b_frames got=%0d want=2", frames_sent); end
    endtask

    task automatic test_parity();
        logic [11:0] bits, ef;
        logic [7:0] e;
        bit stable, to;
        int st;
        do_reset();
        aux_write(1, 8'h07);
        rx_frame(1, 11, bits, stable, st, to);
        e = exp_q.pop_front();
        ef = exp_frame(e, 1);
        total++;
        if (to || !stable || bits[10:0] !== ef[10:0]) begin
            bad++;
            $display("FAIL even_frame got=%b want=%b stable=%0b", bits[10:0], ef[10:0], stable);
        end
        total++;
        if (bits[9] !== 1'b1) begin bad++; $display("FAIL even_parity_bit got=%b want=1", bits[9]); end
        aux_write(2, 8'h07);
        rx_frame(2, 12, bits, stable, st, to);
        e = exp_q.pop_front();
        ef = exp_frame(e, 2);
        total++;
        if (to || !stable || bits !== ef) begin
            bad++;
            $display("FAIL odd_2stop_frame got=%b want=%b stable=%0b", bits, ef, stable);
        end
        total++;
        if (bits[9] !== 1'b0) begin bad++; $display("FAIL odd_parity_bit got=%b want=0", bits[9]); end
        @(negedge clk);
        total++;
        if ({od_busy, od_tx, ev_frames, od_frames} !== {1'b0, 1'b1, 16'd1, 16'd1}) begin
            bad++;
            $display("FAIL aux_end got busy=%b tx=%b ev_frames=%0d od_frames=%0d want 0 1 1 1",
                     od_busy, od_tx, ev_frames, od_frames);
        end
    endtask

    task automatic test_fill();
        logic [11:0] bits, ef;
        logic [7:0] e;
        bit stable, to;
        int st, n0, u0;
        do_reset();
        rst = 1'b1;
        n0 = rd_times.size();
        u0 = underreads;
        for (int i = 0; i < 8; i++) fifo_write(8'(i));
        @(negedge clk);
        total++;
        if (fifo_full !== 1'b1 || rd_times.size() != n0) begin
            bad++;
            $display("FAIL fill_under_reset got full=%b reads=%0d want full=1 reads=0",
                     fifo_full, rd_times.size() - n0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int f = 0; f < 8; f++) begin
            rx_frame(0, 10, bits, stable, st, to);
            e = exp_q.pop_front();
            ef = exp_frame(e, 0);
            total++;
            if (to || !stable || bits[9:0] !== ef[9:0]) begin
                bad++;
                $display("FAIL fill_frame%0d got=%b want=%b stable=%0b", f, bits[9:0], ef[9:0], stable);
            end
        end
        @(negedge clk);
        total++;
        if (frames_sent !== 16'd8 || fifo_empty !== 1'b1 || underreads != u0 || rd_times.size() != n0 + 8) begin
            bad++;
            $display("FAIL fill_end got frames=%0d empty=%b underreads=%0d reads=%0d want 8 1 0 8",
                     frames_sent, fifo_empty, underreads - u0, rd_times.size() - n0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [11:0] bits, ef;
        logic [7:0] e;
        bit stable, to;
        int st, guard;
        fifo_write(8'hA5);
        guard = 0;
        @(negedge clk);
        while (tx !== 1'b0 && guard < 100) begin guard++; @(negedge clk); end
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        total++;
        if ({tx, busy, frames_sent} !== {1'b1, 1'b0, 16'd0} || guard >= 100) begin
            bad++;
            $display("FAIL rst_midframe got tx=%b busy=%b frames=%0d want 1 0 0", tx, busy, frames_sent);
        end
        repeat (10) @(negedge clk);
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_quiet got tx=%b busy=%b want 1 0", tx, busy);
        end
        fifo_write(8'h3C);
        rx_frame(0, 10, bits, stable, st, to);
        e = exp_q.pop_front();
        ef = exp_frame(e, 0);
        total++;
        if (to || !stable || bits[9:0] !== ef[9:0]) begin
            bad++;
            $display("FAIL rst_refill_frame got=%b want=%b stable=%0b", bits[9:0], ef[9:0], stable);
        end
        @(negedge clk);
        total++;
        if (frames_sent !== 16'd1) begin bad++; $display("FAIL rst_refill_frames got=%0d want=1", frames_sent); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_fill();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
